// File: rtl/half_img_merge.sv
// half_img_merge: rebuilds one side-by-side video line from parallel left/right
// half-width pixel streams. Left pixels are forwarded immediately while right
// pixels are parked in a line buffer; the buffer is then replayed directly after
// the last left pixel, so the merged line is 2*N contiguous pixels.
module half_img_merge #(
   parameter int H_ACT = 32,
   parameter int PX_W  = 24
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            de_in,
   input  logic            h_sync_in,
   input  logic            v_sync_in,
   input  logic [PX_W-1:0] pixel_left,
   input  logic [PX_W-1:0] pixel_right,
   output logic            de_out,
   output logic            h_sync_out,
   output logic            v_sync_out,
   output logic [PX_W-1:0] pixel_out,
   output logic            err_overrun
);

   localparam int ADDR_W = $clog2(H_ACT);
   localparam logic [ADDR_W:0] N_MAX = (ADDR_W+1)'(H_ACT);
   localparam logic [ADDR_W:0] N_ONE = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   n_q, n_d;          // pixels captured in the current line
   logic [ADDR_W:0]   rd_q, rd_d;        // index of the next right pixel to emit
   logic              de_out_q, de_out_d;
   logic [PX_W-1:0]   pixel_out_q, pixel_out_d;
   logic              err_q, err_d;
   logic              h_sync_q, h_sync_d;
   logic              v_sync_q, v_sync_d;
   logic [PX_W-1:0]   rd_data_q, rd_data_d;

   logic              wr_en_s;
   logic [ADDR_W-1:0] wr_addr_s;
   logic [ADDR_W-1:0] rd_addr_s;

   logic [PX_W-1:0]   line_buf [H_ACT];

   // Next-state, buffer write and registered-output logic of the merge FSM
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      rd_d        = rd_q;
      de_out_d    = 1'b0;
      pixel_out_d = '0;
      err_d       = err_q;
      h_sync_d    = h_sync_in;
      v_sync_d    = v_sync_in;
      wr_en_s     = 1'b0;
      wr_addr_s   = n_q[ADDR_W-1:0];

      case (state_q)
         ST_IDLE: begin
            if (de_in) begin
               state_d     = ST_LEFT;
               n_d         = N_ONE;
               rd_d        = '0;
               wr_en_s     = 1'b1;
               wr_addr_s   = '0;
               de_out_d    = 1'b1;
               pixel_out_d = pixel_left;
            end else begin
               rd_d = '0;
            end
         end
         ST_LEFT: begin
            if (de_in && (n_q != N_MAX)) begin
               n_d         = n_q + N_ONE;
               wr_en_s     = 1'b1;
               de_out_d    = 1'b1;
               pixel_out_d = pixel_left;
            end else begin
               // End of left half: buf[0] was prefetched, so no gap appears.
               de_out_d    = 1'b1;
               pixel_out_d = rd_data_q;
               if (de_in) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
               if (n_q == N_ONE) begin
                  state_d = de_in ? ST_WAIT : ST_IDLE;
                  rd_d    = '0;
               end else begin
                  state_d = ST_RIGHT;
                  rd_d    = N_ONE;
               end
            end
         end
         ST_RIGHT: begin
            de_out_d    = 1'b1;
            pixel_out_d = rd_data_q;
            // Any input during replay belongs to a line we cannot accept.
            if (de_in) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            if ((rd_q + N_ONE) == n_q) begin
               state_d = de_in ? ST_WAIT : ST_IDLE;
               rd_d    = '0;
            end else begin
               rd_d = rd_q + N_ONE;
            end
         end
         ST_WAIT: begin
            if (!de_in) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            n_d     = '0;
            rd_d    = '0;
         end
      endcase

      // Read-during-write to the same address returns the new pixel so the
      // single-pixel line still prefetches the right value.
      rd_addr_s = rd_d[ADDR_W-1:0];
      if (wr_en_s && (wr_addr_s == rd_addr_s)) begin
         rd_data_d = pixel_right;
      end else begin
         rd_data_d = line_buf[rd_addr_s];
      end
   end

   // FSM state, counters, prefetch register and all outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         n_q         <= '0;
         rd_q        <= '0;
         de_out_q    <= 1'b0;
         pixel_out_q <= '0;
         err_q       <= 1'b0;
         h_sync_q    <= 1'b0;
         v_sync_q    <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         rd_q        <= rd_d;
         de_out_q    <= de_out_d;
         pixel_out_q <= pixel_out_d;
         err_q       <= err_d;
         h_sync_q    <= h_sync_d;
         v_sync_q    <= v_sync_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Right-half line buffer; contents need no reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         line_buf[wr_addr_s] <= pixel_right;
      end
   end

   assign de_out      = de_out_q;
   assign pixel_out   = pixel_out_q;
   assign err_overrun = err_q;
   assign h_sync_out  = h_sync_q;
   assign v_sync_out  = v_sync_q;

endmodule

// File: tb/tb_half_img_merge.sv
// Bench for half_img_merge: line-level reference model predicts the merged
// output stream from a table of (start, length) lines; per-cycle checks.
module tb_half_img_merge;

   localparam int H_ACT = 32;
   localparam int PX_W  = 24;
   localparam int MAXC  = 600;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            de_in = 1'b0;
   logic            h_sync_in = 1'b0;
   logic            v_sync_in = 1'b0;
   logic [PX_W-1:0] pixel_left = '0;
   logic [PX_W-1:0] pixel_right = '0;
   logic            de_out;
   logic            h_sync_out;
   logic            v_sync_out;
   logic [PX_W-1:0] pixel_out;
   logic            err_overrun;

   int total = 0;
   int bad   = 0;

   int ln_s[$];
   int ln_l[$];

   logic            de_a  [MAXC];
   logic            hs_a  [MAXC];
   logic            vs_a  [MAXC];
   logic [PX_W-1:0] l_a   [MAXC];
   logic [PX_W-1:0] r_a   [MAXC];
   logic            exp_de  [MAXC+1];
   logic [PX_W-1:0] exp_px  [MAXC+1];
   logic            exp_err [MAXC+1];
   int              ncyc;

   half_img_merge #(.H_ACT(H_ACT), .PX_W(PX_W)) dut (
      .clk(clk), .rst_n(rst_n), .de_in(de_in),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .pixel_left(pixel_left), .pixel_right(pixel_right),
      .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
      .pixel_out(pixel_out), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Builds stimulus from the line table and predicts the output stream.
   task automatic build(input bit counter_px);
      int busy_last;
      int err_first;
      int last_end;
      for (int c = 0; c < MAXC; c++) begin
         de_a[c] = 1'b0;
         hs_a[c] = 1'($urandom_range(1, 0));
         vs_a[c] = 1'($urandom_range(1, 0));
         l_a[c]  = PX_W'($urandom);
         r_a[c]  = PX_W'($urandom);
      end
      for (int c = 0; c <= MAXC; c++) begin
         exp_de[c] = 1'b0;
         exp_px[c] = '0;
      end
      last_end = 0;
      for (int i = 0; i < ln_s.size(); i++) begin
         for (int k = 0; k < ln_l[i]; k++) begin
            de_a[ln_s[i]+k] = 1'b1;
            if (counter_px) begin
               l_a[ln_s[i]+k] = PX_W'(k);
               r_a[ln_s[i]+k] = PX_W'(256 + k);
            end
         end
         last_end = ln_s[i] + ln_l[i];
      end
      // Line-level model: a line is accepted only when the previous accepted
      // line has finished replaying; otherwise it is dropped and flags error.
      busy_last = -1;
      err_first = MAXC + 10;
      for (int i = 0; i < ln_s.size(); i++) begin
         int s;
         int n;
         s = ln_s[i];
         if (s <= busy_last) begin
            if (s + 1 < err_first) err_first = s + 1;
         end else begin
            n = (ln_l[i] > H_ACT) ? H_ACT : ln_l[i];
            for (int k = 0; k < n; k++) begin
               exp_de[s+1+k]   = 1'b1;
               exp_px[s+1+k]   = l_a[s+k];
               exp_de[s+1+n+k] = 1'b1;
               exp_px[s+1+n+k] = r_a[s+k];
            end
            busy_last = s + 2*n - 1;
            if (ln_l[i] > H_ACT && (s + H_ACT + 1) < err_first) err_first = s + H_ACT + 1;
         end
      end
      for (int c = 0; c <= MAXC; c++) exp_err[c] = (c >= err_first);
      ncyc = last_end + 2*H_ACT + 8;
      if (ncyc > MAXC - 1) ncyc = MAXC - 1;
   endtask

   task automatic apply_reset();
      de_in = 1'b0;
      rst_n = 1'b0;
      #1;
      check_val("rst_de", 32'(de_out), 32'd0);
      check_val("rst_px", 32'(pixel_out), 32'd0);
      check_val("rst_err", 32'(err_overrun), 32'd0);
      check_val("rst_hs", 32'(h_sync_out), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drives one phase; optionally asserts reset after output index rst_at.
   task automatic run_phase(input string name, input int rst_at);
      for (int c = 0; c < ncyc; c++) begin
         de_in       = de_a[c];
         h_sync_in   = hs_a[c];
         v_sync_in   = vs_a[c];
         pixel_left  = l_a[c];
         pixel_right = r_a[c];
         @(posedge clk);
         #1;
         check_val({name, "_de"}, 32'(de_out), 32'(exp_de[c+1]));
         check_val({name, "_px"}, 32'(pixel_out), 32'(exp_px[c+1]));
         check_val({name, "_err"}, 32'(err_overrun), 32'(exp_err[c+1]));
         check_val({name, "_hs"}, 32'(h_sync_out), 32'(hs_a[c]));
         check_val({name, "_vs"}, 32'(v_sync_out), 32'(vs_a[c]));
         if (c + 1 == rst_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_val({name, "_async_de"}, 32'(de_out), 32'd0);
            check_val({name, "_async_px"}, 32'(pixel_out), 32'd0);
            check_val({name, "_async_err"}, 32'(err_overrun), 32'd0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            de_in = 1'b0;
            return;
         end
      end
      de_in = 1'b0;
   endtask

   task automatic set_lines(input int s0, input int l0, input int s1, input int l1,
                            input int s2, input int l2);
      ln_s.delete();
      ln_l.delete();
      ln_s.push_back(s0); ln_l.push_back(l0);
      if (l1 > 0) begin ln_s.push_back(s1); ln_l.push_back(l1); end
      if (l2 > 0) begin ln_s.push_back(s2); ln_l.push_back(l2); end
   endtask

   initial begin
      apply_reset();
      // single full line
      set_lines(2, 32, 0, 0, 0, 0);   build(1'b1); run_phase("full", -1);
      // three lines, blanking 40
      apply_reset();
      set_lines(2, 32, 74, 32, 146, 32); build(1'b1); run_phase("three", -1);
      // overrun during replay: line 2 dropped
      apply_reset();
      set_lines(2, 32, 44, 32, 116, 32); build(1'b1); run_phase("ovr_right", -1);
      // short line
      apply_reset();
      set_lines(2, 20, 0, 0, 0, 0);   build(1'b1); run_phase("short", -1);
      // single-pixel line
      apply_reset();
      set_lines(2, 1, 5, 3, 0, 0);    build(1'b1); run_phase("tiny", -1);
      // long line
      apply_reset();
      set_lines(2, 40, 0, 0, 0, 0);   build(1'b1); run_phase("long", -1);
      // reset at 5th right pixel, then a normal line
      apply_reset();
      set_lines(2, 32, 0, 0, 0, 0);   build(1'b1); run_phase("midrst", 2 + 1 + 32 + 4);
      set_lines(2, 32, 0, 0, 0, 0);   build(1'b1); run_phase("after_rst", -1);
      // randomized line tables
      for (int it = 0; it < 6; it++) begin
         int st;
         apply_reset();
         ln_s.delete();
         ln_l.delete();
         st = 2;
         while (st + 70 < MAXC - 2*H_ACT - 20) begin
            int len;
            len = ($urandom_range(3, 0) == 0) ? $urandom_range(70, 33) : $urandom_range(32, 1);
            ln_s.push_back(st);
            ln_l.push_back(len);
            st = st + len + $urandom_range(60, 1);
         end
         build(1'b0);
         run_phase("rand", -1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
